// File: rtl/riscv_mc_ctrl_fsm_if.sv
// Boundary of the multicycle control unit: instruction fields and ALU flags in, datapath enables out.
// Defining CTRL_PERF_EN adds the CNT_W parameter and the instret/stallCnt counter outputs.
interface riscv_mc_ctrl_fsm_if #(
  parameter int OP_W    = 3,
  parameter int FUNC3_W = 3,
  parameter int IMM_W   = 3
`ifdef CTRL_PERF_EN
  , parameter int CNT_W = 16
`endif
);
  logic [OP_W-1:0]    op;
  logic [FUNC3_W-1:0] func3;
  logic [1:0]         Branch_funct;
  logic               zero;
  logic               less;
  logic               greater;
  logic               memReady;

  logic               PCWrite;
  logic               adrSrc;
  logic               memWrite;
  logic               memReq;
  logic               IRWrite;
  logic               regWrite;
  logic [1:0]         resultSrc;
  logic [1:0]         ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [FUNC3_W-1:0] ALUControl;
  logic [IMM_W-1:0]   immSrc;
  logic               trap;
  logic               busErr;

`ifdef CTRL_PERF_EN
  logic [CNT_W-1:0]   instret;
  logic [CNT_W-1:0]   stallCnt;

  modport master (
    input  op, func3, Branch_funct, zero, less, greater, memReady,
    output PCWrite, adrSrc, memWrite, memReq, IRWrite, regWrite,
           resultSrc, ALUSrcA, ALUSrcB, ALUControl, immSrc, trap, busErr,
           instret, stallCnt
  );
  modport slave (
    output op, func3, Branch_funct, zero, less, greater, memReady,
    input  PCWrite, adrSrc, memWrite, memReq, IRWrite, regWrite,
           resultSrc, ALUSrcA, ALUSrcB, ALUControl, immSrc, trap, busErr,
           instret, stallCnt
  );
`else
  modport master (
    input  op, func3, Branch_funct, zero, less, greater, memReady,
    output PCWrite, adrSrc, memWrite, memReq, IRWrite, regWrite,
           resultSrc, ALUSrcA, ALUSrcB, ALUControl, immSrc, trap, busErr
  );
  modport slave (
    output op, func3, Branch_funct, zero, less, greater, memReady,
    input  PCWrite, adrSrc, memWrite, memReq, IRWrite, regWrite,
           resultSrc, ALUSrcA, ALUSrcB, ALUControl, immSrc, trap, busErr
  );
`endif
endinterface

// File: rtl/riscv_mc_ctrl_fsm.sv
// Multicycle RISC-V control FSM with memReq/memReady handshake, bus timeout, LUI and illegal-op trap.
// Defining CTRL_PERF_EN adds the wrapping instret/stallCnt performance counters.
module riscv_mc_ctrl_fsm #(
  parameter int OP_W        = 3,
  parameter int FUNC3_W     = 3,
  parameter int IMM_W       = 3,
  parameter int MEM_TIMEOUT = 16
`ifdef CTRL_PERF_EN
  , parameter int CNT_W     = 16
`endif
) (
  input logic                 clk,
  input logic                 rst_n,
  riscv_mc_ctrl_fsm_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WRITE, S_MEM_WB, S_EXEC_R,
    S_EXEC_I, S_EXEC_U, S_ALU_WB, S_BRANCH, S_JAL, S_TRAP
  } state_e;

  localparam logic [OP_W-1:0]    OP_R      = OP_W'(0);
  localparam logic [OP_W-1:0]    OP_I      = OP_W'(1);
  localparam logic [OP_W-1:0]    OP_LOAD   = OP_W'(2);
  localparam logic [OP_W-1:0]    OP_STORE  = OP_W'(3);
  localparam logic [OP_W-1:0]    OP_BRANCH = OP_W'(4);
  localparam logic [OP_W-1:0]    OP_JAL    = OP_W'(5);
  localparam logic [OP_W-1:0]    OP_LUI    = OP_W'(6);
  localparam logic [IMM_W-1:0]   IMM_I     = IMM_W'(0);
  localparam logic [IMM_W-1:0]   IMM_S     = IMM_W'(1);
  localparam logic [IMM_W-1:0]   IMM_B     = IMM_W'(2);
  localparam logic [IMM_W-1:0]   IMM_J     = IMM_W'(3);
  localparam logic [IMM_W-1:0]   IMM_U     = IMM_W'(4);
  localparam logic [FUNC3_W-1:0] ALU_SUB   = FUNC3_W'(1);

  localparam int                WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                bus_err_q, bus_err_d;
  logic                pc_write, adr_src, mem_write, mem_req, ir_write, reg_write;
  logic [1:0]          result_src, alu_src_a, alu_src_b;
  logic [FUNC3_W-1:0]  alu_control;
  logic [IMM_W-1:0]    imm_src;
  logic                taken, timeout;

  always_comb begin
    state_d     = state_q;
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    mem_req     = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = '0;
    imm_src     = '0;
    timeout     = 1'b0;

    unique case (bus.Branch_funct)
      2'b00:   taken = bus.zero;
      2'b01:   taken = !bus.zero;
      2'b10:   taken = bus.less;
      default: taken = bus.greater;
    endcase

    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (bus.memReady) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = (bus.op == OP_JAL) ? IMM_J : IMM_B;
        case (bus.op)
          OP_R:               state_d = S_EXEC_R;
          OP_I:               state_d = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_d = S_MEM_ADR;
          OP_BRANCH:          state_d = S_BRANCH;
          OP_JAL:             state_d = S_JAL;
          OP_LUI:             state_d = S_EXEC_U;
          default:            state_d = S_TRAP;
        endcase
      end
      S_MEM_ADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = (bus.op == OP_STORE) ? IMM_S : IMM_I;
        state_d   = (bus.op == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (bus.memReady) state_d = S_MEM_WB;
      end
      S_MEM_WRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (bus.memReady) state_d = S_FETCH;
      end
      S_MEM_WB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a   = 2'b10;
        alu_control = bus.func3;
        state_d     = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        imm_src     = IMM_I;
        alu_control = bus.func3;
        state_d     = S_ALU_WB;
      end
      S_EXEC_U: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
        imm_src   = IMM_U;
        state_d   = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_SUB;
        pc_write    = taken;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_ALU_WB;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase

    // A ready arriving on the last allowed wait cycle completes the access instead of trapping.
    if (MEM_TIMEOUT != 0 && mem_req && !bus.memReady && wait_q == WAIT_LAST) begin
      timeout = 1'b1;
      state_d = S_TRAP;
    end
    bus_err_d = bus_err_q | timeout;
    wait_d    = (mem_req && !bus.memReady && state_d == state_q) ? wait_q + 1'b1 : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Reset gates every output so an in-flight access is dropped the moment rst_n falls.
  assign bus.PCWrite    = rst_n & pc_write;
  assign bus.adrSrc     = rst_n & adr_src;
  assign bus.memWrite   = rst_n & mem_write;
  assign bus.memReq     = rst_n & mem_req;
  assign bus.IRWrite    = rst_n & ir_write;
  assign bus.regWrite   = rst_n & reg_write;
  assign bus.resultSrc  = rst_n ? result_src  : '0;
  assign bus.ALUSrcA    = rst_n ? alu_src_a   : '0;
  assign bus.ALUSrcB    = rst_n ? alu_src_b   : '0;
  assign bus.ALUControl = rst_n ? alu_control : '0;
  assign bus.immSrc     = rst_n ? imm_src     : '0;
  assign bus.trap       = rst_n & (state_q == S_TRAP);
  assign bus.busErr     = rst_n & bus_err_q;

`ifdef CTRL_PERF_EN
  logic [CNT_W-1:0] instret_q, instret_d, stall_q, stall_d;

  always_comb begin
    instret_d = instret_q;
    stall_d   = stall_q;
    if (state_q != S_TRAP) begin
      if (state_d == S_FETCH && state_q != S_FETCH) instret_d = instret_q + 1'b1;
      if (mem_req && !bus.memReady) stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= '0;
      stall_q   <= '0;
    end else begin
      instret_q <= instret_d;
      stall_q   <= stall_d;
    end
  end

  assign bus.instret  = instret_q;
  assign bus.stallCnt = stall_q;
`endif

endmodule

// File: tb/tb_riscv_mc_ctrl_fsm.sv
// Scoreboard bench for riscv_mc_ctrl_fsm: stimulus queues per-cycle expected control vectors,
// a negedge monitor pops and compares them. Perf counter checks build only with CTRL_PERF_EN.
module tb_riscv_mc_ctrl_fsm;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [19:0] exp_q[$];
  string       tag_q[$];

`ifdef CTRL_PERF_EN
  riscv_mc_ctrl_fsm_if #(.CNT_W(4)) bus_if ();
  riscv_mc_ctrl_fsm #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus_if.master));
`else
  riscv_mc_ctrl_fsm_if bus_if ();
  riscv_mc_ctrl_fsm #(.MEM_TIMEOUT(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus_if.master));
`endif

  always #5 clk = ~clk;

  localparam logic [19:0] ZERO = 20'd0;

  // Vector layout: PCWrite adrSrc memWrite memReq IRWrite regWrite resultSrc ALUSrcA ALUSrcB ALUControl immSrc trap busErr
  function automatic logic [19:0] v(input logic pcw, adr, mw, mr, irw, rw,
                                    input logic [1:0] rs, a, b,
                                    input logic [2:0] ctl, imm,
                                    input logic tr, be);
    return {pcw, adr, mw, mr, irw, rw, rs, a, b, ctl, imm, tr, be};
  endfunction

  function automatic logic [19:0] e_fetch(input logic r);
    return v(r, 0, 0, 1, r, 0, 2'b10, 2'b00, 2'b10, 3'd0, 3'd0, 0, 0);
  endfunction
  function automatic logic [19:0] e_dec(input logic [2:0] o);
    return v(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'd0, (o == 3'd5) ? 3'd3 : 3'd2, 0, 0);
  endfunction
  function automatic logic [19:0] e_madr(input logic st);
    return v(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'd0, st ? 3'd1 : 3'd0, 0, 0);
  endfunction
  function automatic logic [19:0] e_exr(input logic [2:0] f);
    return v(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, f, 3'd0, 0, 0);
  endfunction
  function automatic logic [19:0] e_exi(input logic [2:0] f);
    return v(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, f, 3'd0, 0, 0);
  endfunction
  function automatic logic [19:0] e_br(input logic t);
    return v(t, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'd1, 3'd0, 0, 0);
  endfunction
  function automatic logic [19:0] e_trap(input logic be);
    return v(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 1, be);
  endfunction

  localparam logic [19:0] E_MRD = 20'b0_1_0_1_0_0_00_00_00_000_000_0_0;
  localparam logic [19:0] E_MWR = 20'b0_1_1_1_0_0_00_00_00_000_000_0_0;
  localparam logic [19:0] E_MWB = 20'b0_0_0_0_0_1_01_00_00_000_000_0_0;
  localparam logic [19:0] E_AWB = 20'b0_0_0_0_0_1_00_00_00_000_000_0_0;
  localparam logic [19:0] E_EXU = 20'b0_0_0_0_0_0_00_11_01_000_100_0_0;
  localparam logic [19:0] E_JAL = 20'b1_0_0_0_0_0_00_01_10_000_000_0_0;

  // Queue the expectation for the current cycle, then advance past the next rising edge.
  task automatic apply_stimulus(input logic [19:0] e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic check_output();
    logic [19:0] act;
    logic [19:0] exp_v;
    string       tag;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      tag   = tag_q.pop_front();
      act   = {bus_if.PCWrite, bus_if.adrSrc, bus_if.memWrite, bus_if.memReq, bus_if.IRWrite,
               bus_if.regWrite, bus_if.resultSrc, bus_if.ALUSrcA, bus_if.ALUSrcB,
               bus_if.ALUControl, bus_if.immSrc, bus_if.trap, bus_if.busErr};
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("[TB] FAIL %s: got %b expected %b", tag, act, exp_v);
      end
    end
  endtask

  always @(negedge clk) check_output();

  task automatic fetch_decode(input logic [2:0] o);
    bus_if.op       = o;
    bus_if.memReady = 1'b1;
    apply_stimulus(e_fetch(1'b1), "fetch");
    apply_stimulus(e_dec(o), "decode");
  endtask

  task automatic run_rtype(input logic [2:0] f);
    bus_if.func3 = f;
    fetch_decode(3'd0);
    apply_stimulus(e_exr(f), "exec_r");
    apply_stimulus(E_AWB, "alu_wb_r");
  endtask

  task automatic run_branch(input logic [1:0] bf, input logic z, l, g, t);
    bus_if.Branch_funct = bf;
    bus_if.zero         = z;
    bus_if.less         = l;
    bus_if.greater      = g;
    fetch_decode(3'd4);
    apply_stimulus(e_br(t), "branch");
  endtask

`ifdef CTRL_PERF_EN
  task automatic check_perf(input string name, input logic [3:0] act, input logic [3:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask
`endif

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: bench did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n               = 1'b0;
    bus_if.op           = '0;
    bus_if.func3        = '0;
    bus_if.Branch_funct = '0;
    bus_if.zero         = 1'b0;
    bus_if.less         = 1'b0;
    bus_if.greater      = 1'b0;
    bus_if.memReady     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    apply_stimulus(ZERO, "reset_outputs");
    rst_n = 1'b1;

    run_rtype(3'b000);
    run_rtype(3'b001);
    bus_if.func3 = 3'b100;
    fetch_decode(3'd1);
    apply_stimulus(e_exi(3'b100), "exec_i");
    apply_stimulus(E_AWB, "alu_wb_i");
    fetch_decode(3'd6);
    apply_stimulus(E_EXU, "exec_u");
    apply_stimulus(E_AWB, "alu_wb_u");
    fetch_decode(3'd5);
    apply_stimulus(E_JAL, "jal");
    apply_stimulus(E_AWB, "alu_wb_jal");

    fetch_decode(3'd2);
    apply_stimulus(e_madr(1'b0), "mem_adr_load");
    bus_if.memReady = 1'b0;
    repeat (3) apply_stimulus(E_MRD, "mem_read_wait");
    bus_if.memReady = 1'b1;
    apply_stimulus(E_MRD, "mem_read_done");
    apply_stimulus(E_MWB, "mem_wb");

    bus_if.op       = 3'd3;
    bus_if.memReady = 1'b0;
    repeat (2) apply_stimulus(e_fetch(1'b0), "fetch_wait");
    fetch_decode(3'd3);
    apply_stimulus(e_madr(1'b1), "mem_adr_store");
    apply_stimulus(E_MWR, "mem_write_fast");

    run_branch(2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    run_branch(2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
    run_branch(2'b10, 1'b0, 1'b1, 1'b0, 1'b1);
    run_branch(2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
    run_branch(2'b11, 1'b0, 1'b0, 1'b1, 1'b1);
    run_branch(2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    run_branch(2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
    run_branch(2'b00, 1'b0, 1'b1, 1'b0, 1'b0);

    fetch_decode(3'd3);
    apply_stimulus(e_madr(1'b1), "mem_adr_store_late");
    bus_if.memReady = 1'b0;
    repeat (3) apply_stimulus(E_MWR, "mem_write_wait");
    bus_if.memReady = 1'b1;
    apply_stimulus(E_MWR, "mem_write_last_ready");
    run_rtype(3'b010);

    fetch_decode(3'd3);
    apply_stimulus(e_madr(1'b1), "mem_adr_store_to");
    bus_if.memReady = 1'b0;
    repeat (4) apply_stimulus(E_MWR, "mem_write_timeout");
    bus_if.memReady = 1'b1;
    repeat (3) apply_stimulus(e_trap(1'b1), "bus_err_trap");
    rst_n = 1'b0;
    apply_stimulus(ZERO, "reset_in_trap");
    rst_n = 1'b1;

    fetch_decode(3'd7);
    for (int i = 0; i < 20; i++) begin
      bus_if.memReady = 1'($urandom_range(0, 1));
      bus_if.op       = 3'($urandom_range(0, 7));
      apply_stimulus(e_trap(1'b0), "illegal_trap_hold");
    end
    rst_n = 1'b0;
    apply_stimulus(ZERO, "reset_exit_trap");
    rst_n           = 1'b1;
    bus_if.memReady = 1'b0;
    apply_stimulus(e_fetch(1'b0), "fetch_after_reset");
    rst_n = 1'b0;
    #1;
    apply_stimulus(ZERO, "reset_mid_fetch");
    rst_n = 1'b1;
    run_rtype(3'b111);

`ifdef CTRL_PERF_EN
    rst_n = 1'b0;
    #1;
    check_perf("instret_reset", bus_if.instret, 4'd0);
    check_perf("stall_reset", bus_if.stallCnt, 4'd0);
    @(posedge clk);
    #1;
    rst_n           = 1'b1;
    bus_if.memReady = 1'b0;
    repeat (2) apply_stimulus(e_fetch(1'b0), "perf_fetch_wait");
    for (int i = 0; i < 17; i++) run_rtype(3'b000);
    check_perf("instret_wrap", bus_if.instret, 4'd1);
    check_perf("stall_count", bus_if.stallCnt, 4'd2);
`endif

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
